// File: rtl/display_scan_if.sv
`default_nettype none
// display_scan_if: digit bus, blink controls and scan outputs of the display scanner.
// Rev 1.0
interface display_scan_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic                    blink_en;
  logic [3:0]              bcd_out;
  logic [NUM_DIGITS-1:0]   an_n;
  logic                    frame_tick;

  modport master (
    output digits_in, blink_mask, blink_en,
    input  bcd_out, an_n, frame_tick
  );

  modport slave (
    input  digits_in, blink_mask, blink_en,
    output bcd_out, an_n, frame_tick
  );
endinterface
`default_nettype wire

// File: rtl/display_scan.sv
`default_nettype none
// display_scan: time-multiplexed 7-segment scan with anode guard interval and field blink.
// Rev 1.0
module display_scan #(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 100000,
  parameter int GUARD        = 2,
  parameter int BLINK_CYCLES = 25000000
) (
  input  logic         clk,
  input  logic         rst,
  display_scan_if.slave bus
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] GUARD_W    = DW'(GUARD);
  localparam logic [BW-1:0] BCNT_LAST  = BW'(BLINK_CYCLES - 1);
  localparam logic [3:0]    BLANK      = 4'd10;

  logic [IW-1:0]           idx_q,    idx_d;
  logic [DW-1:0]           dwell_q,  dwell_d;
  logic [BW-1:0]           bcnt_q,   bcnt_d;
  logic                    phase_q,  phase_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]   an_n_q,   an_n_d;
  logic [3:0]              bcd_q,    bcd_d;
  logic                    tick_q,   tick_d;

  logic       at_start;
  logic [3:0] cur_digit;
  logic       blank;

  always_comb begin
    at_start = (idx_q == '0) && (dwell_q == '0);

    // Reading from the next-state snapshot gives slot 0 the fresh digits_in value.
    shadow_d  = at_start ? bus.digits_in : shadow_q;
    cur_digit = BLANK;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) cur_digit = shadow_d[4*i +: 4];
    end

    an_n_d = '1;
    if (dwell_q >= GUARD_W) an_n_d[idx_q] = 1'b0;

    blank  = bus.blink_en & bus.blink_mask[idx_q] & ~phase_q;
    bcd_d  = blank ? BLANK : cur_digit;
    tick_d = at_start;

    dwell_d = dwell_q + 1'b1;
    idx_d   = idx_q;
    if (dwell_q == DWELL_LAST) begin
      dwell_d = '0;
      idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    bcnt_d  = bcnt_q + 1'b1;
    phase_d = phase_q;
    if (bcnt_q == BCNT_LAST) begin
      bcnt_d  = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= '0;
      dwell_q  <= '0;
      bcnt_q   <= '0;
      phase_q  <= 1'b1;
      shadow_q <= {NUM_DIGITS{BLANK}};
      an_n_q   <= '1;
      bcd_q    <= BLANK;
      tick_q   <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      dwell_q  <= dwell_d;
      bcnt_q   <= bcnt_d;
      phase_q  <= phase_d;
      shadow_q <= shadow_d;
      an_n_q   <= an_n_d;
      bcd_q    <= bcd_d;
      tick_q   <= tick_d;
    end
  end

  assign bus.an_n       = an_n_q;
  assign bus.bcd_out    = bcd_q;
  assign bus.frame_tick = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_display_scan.sv
`default_nettype none
// tb_display_scan: directed checks of scan order, snapshot, blink, mid-frame reset and pass-through.
// Rev 1.0
module tb_display_scan;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;
  int   run_len [4];

  display_scan_if #(.NUM_DIGITS(4)) bus ();

  display_scan #(
    .NUM_DIGITS  (4),
    .SCAN_DIV    (4),
    .GUARD       (1),
    .BLINK_CYCLES(32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] an_e, input logic [3:0] bcd_e,
                     input logic tk_e);
    step();
    compared++;
    assert ({bus.an_n, bus.bcd_out, bus.frame_tick} === {an_e, bcd_e, tk_e})
    else begin
      mismatched++;
      $error("FAIL %s: an_n/bcd/tick got %b/%0d/%b expected %b/%0d/%b",
             tag, bus.an_n, bus.bcd_out, bus.frame_tick, an_e, bcd_e, tk_e);
    end
  endtask

  // One slot: a guard clock with all anodes off, then three clocks with anode s low.
  task automatic check_slot(input string tag, input int s, input logic [3:0] b);
    logic [3:0] m;
    m = 4'b0001 << s;
    chk(tag, 4'hF, b, (s == 0));
    repeat (3) chk(tag, ~m, b, 1'b0);
  endtask

  task automatic check_frame(input string tag, input logic [15:0] codes);
    for (int s = 0; s < 4; s++) check_slot(tag, s, codes[4*s +: 4]);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst            = 1'b1;
    bus.digits_in  = 16'h4321;
    bus.blink_en   = 1'b0;
    bus.blink_mask = 4'b0000;

    chk("reset", 4'hF, 4'd10, 1'b0);
    chk("reset_hold", 4'hF, 4'd10, 1'b0);

    // Basic scan order and frame tick spacing.
    rst = 1'b0;
    check_frame("frame1", 16'h4321);

    // Mid-frame digit change stays hidden until the next frame.
    check_slot("frame2", 0, 4'd1);
    check_slot("frame2", 1, 4'd2);
    bus.digits_in = 16'h9876;
    check_slot("frame2_mid", 2, 4'd3);
    check_slot("frame2_mid", 3, 4'd4);
    check_frame("frame3", 16'h9876);

    // Blink: phase 0 covers outputs 33..64 clocks after release.
    rst            = 1'b1;
    bus.digits_in  = 16'h5959;
    bus.blink_en   = 1'b1;
    bus.blink_mask = 4'b0011;
    chk("blink_rst", 4'hF, 4'd10, 1'b0);
    rst = 1'b0;
    check_frame("blink_f0", 16'h5959);
    check_frame("blink_f1", 16'h5959);
    check_slot("blink_f2", 0, 4'd10);
    check_slot("blink_f2", 1, 4'd10);
    chk("blink_f2_s2", 4'hF, 4'd9, 1'b0);
    chk("blink_f2_s2", 4'b1011, 4'd9, 1'b0);

    // Reset at idx=2, dwell=2 while in the blanked phase.
    rst = 1'b1;
    chk("mid_rst", 4'hF, 4'd10, 1'b0);
    rst = 1'b0;
    bus.digits_in = 16'h1357;
    check_frame("post_rst_f0", 16'h1357);
    check_frame("post_rst_f1", 16'h1357);
    check_frame("post_rst_f2", 16'h13AA);

    // Random digits and reset pulses: anode exclusivity and on-time bound.
    for (int j = 0; j < 4; j++) run_len[j] = 0;
    for (int n = 0; n < 1000; n++) begin
      int  zeros;
      logic too_long;
      bus.digits_in  = 16'($urandom);
      bus.blink_mask = 4'($urandom);
      bus.blink_en   = 1'($urandom);
      rst            = ($urandom_range(0, 39) == 0);
      step();
      zeros    = $countones(~bus.an_n);
      too_long = 1'b0;
      for (int j = 0; j < 4; j++) begin
        run_len[j] = bus.an_n[j] ? 0 : run_len[j] + 1;
        if (run_len[j] > 3) too_long = 1'b1;
      end
      compared++;
      assert ((zeros <= 1) === 1'b1)
      else begin
        mismatched++;
        $error("FAIL rand_onehot: an_n got %b expected at most one low bit", bus.an_n);
      end
      compared++;
      assert (too_long === 1'b0)
      else begin
        mismatched++;
        $error("FAIL rand_ontime: an_n %b got run longer than 3 expected <= 3", bus.an_n);
      end
    end

    // Codes 10..15 pass through unchanged.
    rst            = 1'b1;
    bus.blink_en   = 1'b0;
    bus.blink_mask = 4'b0000;
    bus.digits_in  = 16'hFBA0;
    chk("passthru_rst", 4'hF, 4'd10, 1'b0);
    rst = 1'b0;
    check_frame("passthru", 16'hFBA0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
